sram_sched: RTL

// - Cycle-accurate scheduler for the shared external SRAM (va/vd, n_vrd/n_vwr) at 168 MHz.
// - Arbitrates three requesters: video fetch (real-time), ROM-to-RAM init writer, CPU bus.
// - Generates SRAM strobe timing, latches read data and returns a one-cycle ack per access.
// - Sits between the video, init and CPU front-ends and the top-level SRAM pins.

---
 rtl/sram_sched_pkg.sv | 30 +++
 rtl/sram_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sram_sched_pkg.sv
// Shared types and widths for the external SRAM scheduler.
package sram_sched_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int SCNT_W = 3;  // strobe-length counter
  localparam int WAIT_W = 5;  // video wait counter (saturating)

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } sram_state_t;

  typedef enum logic [1:0] {
    OWN_VID  = 2'd0,
    OWN_INIT = 2'd1,
    OWN_CPU  = 2'd2
  } sram_owner_t;

  // One latched access: who owns the bus and what it asked for.
  typedef struct packed {
    sram_owner_t         owner;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_sched.sv
// Shared SRAM scheduler: fixed-priority arbitration (video > init > cpu),
// strobe sequencing IDLE -> SETUP -> STROBE -> HOLD, read capture and acks.
// All pin-facing outputs come straight from flops so the SRAM strobes are
// glitch-free and drop to their idle levels as soon as rst_n asserts.
module sram_sched
  import sram_sched_pkg::*;
#(
  parameter int RD_CYC = 4,   // n_vrd low cycles, 2..8
  parameter int WR_CYC = 3,   // n_vwr low cycles, 1..8
  parameter int VID_DL = 12   // video wait limit before video_late
) (
  input  logic              clk168,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              init_req,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata,
  output logic              init_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_doe,
  input  logic [DATA_W-1:0] sram_din,
  output logic              n_vrd,
  output logic              n_vwr,
  output logic              video_late
);

  localparam logic [SCNT_W-1:0] RD_LD = SCNT_W'(RD_CYC - 1);
  localparam logic [SCNT_W-1:0] WR_LD = SCNT_W'(WR_CYC - 1);

  sram_state_t       state_q, state_d;
  sram_req_t         acc_q, acc_d, gnt;
  logic              gnt_any;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [WAIT_W-1:0] vwait_q, vwait_d;
  logic              late_q, late_d;
  logic              n_vrd_q, n_vrd_d, n_vwr_q, n_vwr_d, doe_q, doe_d;
  logic              vack_q, vack_d, iack_q, iack_d, cack_q, cack_d;
  logic [DATA_W-1:0] vrd_q, vrd_d, crd_q, crd_d;
  logic              rd_last, vid_busy, vid_gnt;

  // Fixed-priority arbiter: video is real-time, then init, then cpu.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    if (vid_req) begin
      gnt_any   = 1'b1;
      gnt.owner = OWN_VID;
      gnt.we    = 1'b0;
      gnt.addr  = vid_addr;
    end else if (init_req) begin
      gnt_any   = 1'b1;
      gnt.owner = OWN_INIT;
      gnt.we    = 1'b1;
      gnt.addr  = init_addr;
      gnt.wdata = init_wdata;
    end else if (cpu_req) begin
      gnt_any   = 1'b1;
      gnt.owner = OWN_CPU;
      gnt.we    = cpu_we;
      gnt.addr  = cpu_addr;
      gnt.wdata = cpu_wdata;
    end
  end

  // Access FSM next state; the owner/addr/data are frozen at grant.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    scnt_d  = scnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = SETUP;
          acc_d   = gnt;
        end
      end
      SETUP: begin
        state_d = STROBE;
        scnt_d  = acc_q.we ? WR_LD : RD_LD;
      end
      STROBE: begin
        if (scnt_q == '0) state_d = HOLD;
        else              scnt_d  = scnt_q - 1'b1;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin and ack levels for the upcoming cycle, registered below.
  always_comb begin
    n_vrd_d = !(state_d == STROBE && !acc_d.we);
    n_vwr_d = !(state_d == STROBE &&  acc_d.we);
    doe_d   = acc_d.we && (state_d != IDLE);
    vack_d  = (state_d == HOLD) && (acc_d.owner == OWN_VID);
    iack_d  = (state_d == HOLD) && (acc_d.owner == OWN_INIT);
    cack_d  = (state_d == HOLD) && (acc_d.owner == OWN_CPU);
  end

  // Read data is captured on the last low cycle of n_vrd into the owner's
  // register only; the other requester's data is left untouched.
  always_comb begin
    rd_last = (state_q == STROBE) && !acc_q.we && (scnt_q == '0);
    vrd_d   = vrd_q;
    crd_d   = crd_q;
    if (rd_last && acc_q.owner == OWN_VID) vrd_d = sram_din;
    if (rd_last && acc_q.owner == OWN_CPU) crd_d = sram_din;
  end

  // Video wait counter: only counts while video is queued behind another
  // owner, not during its own access; sticky late flag on overrun.
  always_comb begin
    vid_busy = (state_q != IDLE) && (acc_q.owner == OWN_VID);
    vid_gnt  = (state_q == IDLE) && vid_req;
    vwait_d  = vwait_q;
    if (vid_gnt)
      vwait_d = '0;
    else if (vid_req && !vid_busy && vwait_q != '1)
      vwait_d = vwait_q + 1'b1;
    late_d = late_q | (int'(vwait_q) > VID_DL);
  end

  // State and output registers; async reset aborts any access in flight.
  always_ff @(posedge clk168 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      scnt_q  <= '0;
      vwait_q <= '0;
      late_q  <= 1'b0;
      n_vrd_q <= 1'b1;
      n_vwr_q <= 1'b1;
      doe_q   <= 1'b0;
      vack_q  <= 1'b0;
      iack_q  <= 1'b0;
      cack_q  <= 1'b0;
      vrd_q   <= '0;
      crd_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      scnt_q  <= scnt_d;
      vwait_q <= vwait_d;
      late_q  <= late_d;
      n_vrd_q <= n_vrd_d;
      n_vwr_q <= n_vwr_d;
      doe_q   <= doe_d;
      vack_q  <= vack_d;
      iack_q  <= iack_d;
      cack_q  <= cack_d;
      vrd_q   <= vrd_d;
      crd_q   <= crd_d;
    end
  end

  assign sram_a     = acc_q.addr;
  assign sram_dout  = acc_q.wdata;
  assign sram_doe   = doe_q;
  assign n_vrd      = n_vrd_q;
  assign n_vwr      = n_vwr_q;
  assign vid_ack    = vack_q;
  assign init_ack   = iack_q;
  assign cpu_ack    = cack_q;
  assign vid_rdata  = vrd_q;
  assign cpu_rdata  = crd_q;
  assign video_late = late_q;

endmodule
